// File: rtl/exe_stage_md.sv
// exe_stage_md: execute stage between ID and MEM.
//   - One-hot ALU:
//       bit0 add, bit1 sub, bit2 slt, bit3 sltu, bit4 and, bit5 nor,
//       bit6 or, bit7 xor, bit8 sll, bit9 srl, bit10 sra, bit11 lui (src2 pass).
//   - Iterative restoring divider (DATA_W iterations) that stalls the stage.
//   - Sub-word store lane generation and misalignment detection.
//   - Memory request issued only on the cycle the instruction leaves EXE.
// Ports:
//   clk/resetn                      clock, synchronous active-low reset
//   flush                           kill instruction in EXE, abort divide
//   id_to_exe_valid/exe_allowin     ID -> EXE handshake
//   in_*                            decoded instruction fields and operands
//   mem_allowin/exe_to_mem_valid    EXE -> MEM handshake
//   out_*                           result, load info, misalign flag, sideband
//   data_sram_*                     data memory request
module exe_stage_md #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PASS_W = 70
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          flush,
  input  logic                          id_to_exe_valid,
  output logic                          exe_allowin,
  input  logic [11:0]                   in_alu_op,
  input  logic                          in_div,
  input  logic                          in_div_signed,
  input  logic                          in_div_rem,
  input  logic                          in_mem_re,
  input  logic                          in_mem_we,
  input  logic [1:0]                    in_mem_size,
  input  logic [DATA_W-1:0]             in_src1,
  input  logic [DATA_W-1:0]             in_src2,
  input  logic [DATA_W-1:0]             in_store_data,
  input  logic [PASS_W-1:0]             in_pass,
  input  logic                          mem_allowin,
  output logic                          exe_to_mem_valid,
  output logic [DATA_W-1:0]             out_result,
  output logic                          out_res_from_mem,
  output logic [1:0]                    out_mem_size,
  output logic [$clog2(DATA_W/8)-1:0]   out_addr_low,
  output logic                          out_ale,
  output logic [PASS_W-1:0]             out_pass,
  output logic                          data_sram_en,
  output logic [DATA_W/8-1:0]           data_sram_we,
  output logic [DATA_W-1:0]             data_sram_addr,
  output logic [DATA_W-1:0]             data_sram_wdata
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned LB = $clog2(NB);
  localparam int unsigned SW = $clog2(DATA_W);
  localparam int unsigned CW = SW + 1;

  typedef struct packed {
    logic [11:0]       alu_op;
    logic              div;
    logic              div_signed;
    logic              div_rem;
    logic              mem_re;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [DATA_W-1:0] store_data;
    logic [PASS_W-1:0] pass;
  } instr_t;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

  instr_t            instr_d, instr_q;
  logic              exe_valid_d, exe_valid_q;
  div_state_e        state_d, state_q;
  logic [CW-1:0]     cnt_d, cnt_q;
  logic [DATA_W-1:0] quo_d, quo_q, rem_d, rem_q, dvs_d, dvs_q;
  logic              q_neg_d, q_neg_q, r_neg_d, r_neg_q, dvz_d, dvz_q;
  logic              ready_go;
  logic [DATA_W:0]   rem_shift, diff;
  logic [DATA_W-1:0] alu_res, div_res, quo_fix, rem_fix;
  logic [SW-1:0]     sh;
  logic              is_mem, ale;
  logic [3:0]        size_bytes;
  logic [LB-1:0]     low_mask, addr_low, idx;
  logic [NB-1:0]     lane_mask;

  // Handshake and instruction capture; flush wins over a simultaneous capture.
  always_comb begin
    ready_go    = instr_q.div ? (state_q == StDone) : 1'b1;
    exe_allowin = ~exe_valid_q | (ready_go & mem_allowin);
    exe_valid_d = exe_valid_q;
    instr_d     = instr_q;
    if (flush) begin
      exe_valid_d = 1'b0;
    end else if (exe_allowin) begin
      exe_valid_d = id_to_exe_valid;
      if (id_to_exe_valid) begin
        instr_d = '{alu_op: in_alu_op, div: in_div, div_signed: in_div_signed,
                    div_rem: in_div_rem, mem_re: in_mem_re, mem_we: in_mem_we,
                    mem_size: in_mem_size, src1: in_src1, src2: in_src2,
                    store_data: in_store_data, pass: in_pass};
      end
    end
  end

  // ALU
  always_comb begin
    alu_res = '0;
    sh      = instr_q.src2[SW-1:0];
    unique case (1'b1)
      instr_q.alu_op[0]:  alu_res = instr_q.src1 + instr_q.src2;
      instr_q.alu_op[1]:  alu_res = instr_q.src1 - instr_q.src2;
      instr_q.alu_op[2]:  alu_res = {{(DATA_W-1){1'b0}},
                                     $signed(instr_q.src1) < $signed(instr_q.src2)};
      instr_q.alu_op[3]:  alu_res = {{(DATA_W-1){1'b0}}, instr_q.src1 < instr_q.src2};
      instr_q.alu_op[4]:  alu_res = instr_q.src1 & instr_q.src2;
      instr_q.alu_op[5]:  alu_res = ~(instr_q.src1 | instr_q.src2);
      instr_q.alu_op[6]:  alu_res = instr_q.src1 | instr_q.src2;
      instr_q.alu_op[7]:  alu_res = instr_q.src1 ^ instr_q.src2;
      instr_q.alu_op[8]:  alu_res = instr_q.src1 << sh;
      instr_q.alu_op[9]:  alu_res = instr_q.src1 >> sh;
      instr_q.alu_op[10]: alu_res = $unsigned($signed(instr_q.src1) >>> sh);
      instr_q.alu_op[11]: alu_res = instr_q.src2;
      default:            alu_res = '0;
    endcase
  end

  // Divider: magnitudes loaded in IDLE (T0), one restoring step per BUSY cycle,
  // signs applied combinationally while DONE holds the raw result.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    dvz_d     = dvz_q;
    rem_shift = {rem_q, quo_q[DATA_W-1]};
    diff      = rem_shift - {1'b0, dvs_q};
    unique case (state_q)
      StIdle: begin
        if (exe_valid_q && instr_q.div && !flush) begin
          state_d = StBusy;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = (instr_q.div_signed && instr_q.src1[DATA_W-1]) ? -instr_q.src1
                                                                   : instr_q.src1;
          dvs_d   = (instr_q.div_signed && instr_q.src2[DATA_W-1]) ? -instr_q.src2
                                                                   : instr_q.src2;
          q_neg_d = instr_q.div_signed & (instr_q.src1[DATA_W-1] ^ instr_q.src2[DATA_W-1]);
          r_neg_d = instr_q.div_signed & instr_q.src1[DATA_W-1];
          dvz_d   = (instr_q.src2 == '0);
        end
      end
      StBusy: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (!diff[DATA_W]) begin
            rem_d = diff[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = rem_shift[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
          end
          if (cnt_q == CW'(DATA_W - 1)) state_d = StDone;
        end
      end
      StDone: begin
        if (flush || mem_allowin) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    quo_fix = dvz_q ? '1 : (q_neg_q ? -quo_q : quo_q);
    rem_fix = r_neg_q ? -rem_q : rem_q;
    div_res = instr_q.div_rem ? rem_fix : quo_fix;
  end

  // Memory access: alignment, byte lanes, lane-replicated store data.
  always_comb begin
    is_mem     = (instr_q.mem_re | instr_q.mem_we) & ~instr_q.div;
    size_bytes = 4'd1 << instr_q.mem_size;
    low_mask   = LB'(size_bytes - 4'd1);
    addr_low   = alu_res[LB-1:0];
    // Access wider than the datapath counts as misaligned.
    ale        = is_mem & ((32'(size_bytes) > NB) | (|(addr_low & low_mask)));
    lane_mask  = '0;
    idx        = '0;
    data_sram_wdata = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      lane_mask[i] = (i < 32'(size_bytes));
      idx = LB'(i) & low_mask;
      data_sram_wdata[i*8 +: 8] = instr_q.store_data[{idx, 3'b000} +: 8];
    end
    data_sram_we     = (instr_q.mem_we & ~instr_q.div) ? (lane_mask << addr_low) : '0;
    data_sram_en     = exe_valid_q & is_mem & ~ale & ~flush & mem_allowin;
    data_sram_addr   = alu_res;
    exe_to_mem_valid = exe_valid_q & ready_go & ~flush;
    out_result       = instr_q.div ? div_res : alu_res;
    out_res_from_mem = instr_q.mem_re & ~instr_q.div;
    out_mem_size     = instr_q.mem_size;
    out_addr_low     = addr_low;
    out_ale          = ale;
    out_pass         = instr_q.pass;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      exe_valid_q <= 1'b0;
      instr_q     <= '0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dvz_q       <= 1'b0;
    end else begin
      exe_valid_q <= exe_valid_d;
      instr_q     <= instr_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      dvz_q       <= dvz_d;
    end
  end

endmodule
